// File: rtl/gouram_trace_pkg.sv
// Shared constants and types for the Gouram trace path (trace unit and trace sink).
package gouram_trace_pkg;

  localparam int TRACE_W         = 129;
  localparam int TRACE_PAYLOAD_W = 128;
  localparam int BEAT_W          = 32;
  localparam int BEATS_PER_REC   = 4;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    BEAT2,
    BEAT3
  } sink_state_t;

endpackage

// File: rtl/gouram_trace_fifo.sv
// Synchronous record FIFO; push/pop are self-qualified so a push while full only
// lands when a pop frees the slot in the same cycle.
module gouram_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage array is not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gouram_trace_sink.sv
// Gouram trace sink: buffers 129-bit trace records and serialises each into four
// 32-bit beats on a valid/ready stream, counting records dropped on overflow.
module gouram_trace_sink
  import gouram_trace_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OVF_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TRACE_W-1:0]     trace_data_i,
  input  logic                   clear_i,
  output logic [BEAT_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [OVF_WIDTH-1:0]   overflow_count
);

  localparam int HOLD_W = BEAT_W * BEATS_PER_REC;

  sink_state_t                state, state_next;
  logic [HOLD_W-1:0]          hold;
  logic [TRACE_PAYLOAD_W-1:0] head;
  logic [BEAT_W-1:0]          data_next;
  logic                       valid_next, last_next;
  logic                       strobe, full, empty, accept, load;

  assign strobe = trace_data_i[TRACE_W-1];
  assign accept = out_valid & out_ready;
  // Reload straight from BEAT3 so consecutive records stream without a bubble.
  assign load   = ~clear_i & ~empty & ((state == IDLE) | ((state == BEAT3) & accept));

  gouram_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_PAYLOAD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .push  (strobe),
    .pop   (load),
    .wdata (trace_data_i[TRACE_PAYLOAD_W-1:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_level)
  );

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    data_next  = out_data;
    valid_next = out_valid;
    last_next  = out_last;
    if (clear_i) begin
      state_next = IDLE;
      data_next  = '0;
      valid_next = 1'b0;
      last_next  = 1'b0;
    end else if (load) begin
      state_next = BEAT0;
      data_next  = head[0 +: BEAT_W];
      valid_next = 1'b1;
      last_next  = 1'b0;
    end else if (accept) begin
      case (state)
        BEAT0: begin
          state_next = BEAT1;
          data_next  = hold[BEAT_W*1 +: BEAT_W];
        end
        BEAT1: begin
          state_next = BEAT2;
          data_next  = hold[BEAT_W*2 +: BEAT_W];
        end
        BEAT2: begin
          state_next = BEAT3;
          data_next  = hold[BEAT_W*3 +: BEAT_W];
          last_next  = 1'b1;
        end
        BEAT3: begin
          state_next = IDLE;
          data_next  = '0;
          valid_next = 1'b0;
          last_next  = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      out_data  <= data_next;
      out_valid <= valid_next;
      out_last  <= last_next;
      if (load) hold <= head;
    end
  end

  // A strobe while full is dropped unless a load frees the slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_count <= '0;
    end else if (clear_i) begin
      overflow_count <= '0;
    end else if (strobe & full & ~load & (overflow_count != '1)) begin
      overflow_count <= overflow_count + OVF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gouram_trace_sink.sv
// Scoreboard bench for gouram_trace_sink: directed scenarios plus random traffic
// against a record-level queue model.
module tb_gouram_trace_sink;
  import gouram_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int OVFW  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [TRACE_W-1:0] trace_data;
  logic               clear;
  logic               out_ready;
  logic [BEAT_W-1:0]  out_data;
  logic               out_valid;
  logic               out_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [OVFW-1:0]    overflow_count;

  gouram_trace_sink #(.DEPTH(DEPTH), .OVF_WIDTH(OVFW)) dut (
    .clk            (clk),
    .rst            (rst),
    .trace_data_i   (trace_data),
    .clear_i        (clear),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record-level reference model: queued records, beats left on the record in flight.
  typedef struct { logic [31:0] d; logic l; } beat_t;
  logic [127:0] mq[$];
  beat_t        exp_q[$];
  int           rem = 0;
  int           ovf = 0;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    rem = 0;
    ovf = 0;
  endtask

  task automatic model_step(input logic stb, input logic [127:0] pl, input logic rdy, input logic clr);
    bit acc, pop;
    if (clr) begin
      model_reset();
      return;
    end
    acc = (rem > 0) && rdy;
    pop = ((rem == 0) || (rem == 1 && acc)) && (mq.size() > 0);
    if (acc) rem--;
    if (pop) begin
      void'(mq.pop_front());
      rem = 4;
    end
    if (stb) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(pl);
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          b.d = pl[32*k +: 32];
          b.l = (k == 3);
          exp_q.push_back(b);
        end
      end else if (ovf < (1 << OVFW) - 1) begin
        ovf++;
      end
    end
  endtask

  task automatic check_model();
    check("fifo_level", fifo_level, mq.size());
    check("overflow_count", overflow_count, ovf);
    check("out_valid", out_valid, rem > 0);
    check("out_last", out_last, rem == 1);
  endtask

  // Called in the quiet phase just after a falling edge; returns in the same phase.
  task automatic cycle(input logic stb, input logic [127:0] pl, input logic rdy, input logic clr);
    trace_data = {stb, pl};
    out_ready  = rdy;
    clear      = clr;
    @(posedge clk);
    model_step(stb, pl, rdy, clr);
    @(negedge clk);
    check_model();
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: snapshot outputs on the falling edge, resolve the handshake on the rising edge.
  logic        snap_v, snap_l, held, held_l;
  logic [31:0] snap_d, held_d;
  initial held = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (held) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, held_d);
      check("stall_last", out_last, held_l);
    end
    snap_v = out_valid;
    snap_d = out_data;
    snap_l = out_last;
  end

  always @(posedge clk) begin
    if (rst || clear) begin
      held = 1'b0;
    end else if (snap_v && out_ready) begin
      held = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_data", snap_d, b.d);
        check("beat_last", snap_l, b.l);
      end
    end else if (snap_v) begin
      held   = 1'b1;
      held_d = snap_d;
      held_l = snap_l;
    end
  end

  localparam logic [127:0] P1 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    int first_v, last_v, n_v, peak;
    rst = 1'b1; trace_data = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow_count, 0);
    #1 rst = 1'b0;

    // Single record: out_valid appears after the second edge counting the strobe edge.
    cycle(1'b1, P1, 1'b1, 1'b0);
    check("lat_not_yet", out_valid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("lat_valid", out_valid, 1'b1);
    check("lat_beat0", out_data, 32'h11111111);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_idle", out_valid, 1'b0);

    // Backpressure during BEAT1.
    cycle(1'b1, P1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("bp_hold_data", out_data, 32'h22222222);
    end
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
    check("bp_drained", exp_q.size(), 0);

    // Back-to-back: 12 contiguous beats, peak fifo_level 2.
    first_v = -1; last_v = -1; n_v = 0; peak = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(i < 3, rnd128(), 1'b1, 1'b0);
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    check("b2b_beats", n_v, 12);
    check("b2b_contiguous", last_v - first_v, 11);
    check("b2b_peak_level", peak, 2);

    // Overflow: 11 strobes with no consumer.
    for (int i = 0; i < 11; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0);
    check("ovf_level", fifo_level, 8);
    check("ovf_count", overflow_count, 2);

    // Full FIFO with a strobe landing on the BEAT3 accept.
    for (int i = 0; i < 8 && rem != 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("reach_beat3", out_last, 1'b1);
    cycle(1'b1, rnd128(), 1'b1, 1'b0);
    check("fullpop_level", fifo_level, 8);
    check("fullpop_ovf", overflow_count, 2);
    for (int i = 0; i < 45; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("ovf_drained", exp_q.size(), 0);

    // Clear mid-BEAT2 with four records queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("pre_clear_level", fifo_level, 4);
    cycle(1'b1, rnd128(), 1'b1, 1'b1);
    check("clr_valid", out_valid, 1'b0);
    check("clr_level", fifo_level, 0);
    check("clr_ovf", overflow_count, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 2) != 0, rnd128(), $urandom_range(0, 4) < 3,
            $urandom_range(0, 79) == 0);
    for (int i = 0; i < 45; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("rand_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a record.
    for (int i = 0; i < 11; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_data", out_data, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_level", fifo_level, 0);
    check("arst_ovf", overflow_count, 0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, P1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
